// File: rtl/memory_pkg.sv
// Shared types for the memory pipeline stage.
//   - execute -> memory record (excute_data_t), memory -> writeback record
//     (memory_data_t), forwarding record (tran_t)
//   - data bus request/response structs (dbus_req_t / dbus_resp_t)
//   - FSM state encoding and small size/alignment helpers
package memory_pkg;

  typedef logic [63:0] word_t;
  typedef logic [2:0]  msize_t;   // log2 of access size in bytes

  typedef enum logic [2:0] {
    OP_ALU = 3'd0,
    OP_LD  = 3'd1,
    OP_SD  = 3'd2,
    OP_BR  = 3'd3
  } op_t;

  typedef struct packed {
    op_t  op;
    logic regwrite;
  } ctl_t;

  typedef struct packed {
    word_t       pc;
    logic        valid;
    logic [31:0] raw_instr;
    ctl_t        ctl;
    logic [4:0]  dst;
    word_t       rd2;
    word_t       result;
  } excute_data_t;

  typedef struct packed {
    word_t       pc;
    logic        valid;
    logic [31:0] raw_instr;
    ctl_t        ctl;
    logic [4:0]  dst;
    word_t       rd2;
    word_t       result;    // final writeback value
    logic        misalign;
  } memory_data_t;

  typedef struct packed {
    word_t      data;
    logic [4:0] dst;
    logic       ismem;
  } tran_t;

  typedef struct packed {
    logic       valid;
    word_t      addr;
    msize_t     size;
    logic [7:0] strobe;
    word_t      data;
  } dbus_req_t;

  typedef struct packed {
    logic  data_ok;
    word_t data;
  } dbus_resp_t;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } mem_state_t;

  // Byte-lane mask of an access of 2^size bytes at lane 0.
  function automatic logic [7:0] lane_mask(input logic [1:0] size);
    case (size)
      2'd0:    lane_mask = 8'h01;
      2'd1:    lane_mask = 8'h03;
      2'd2:    lane_mask = 8'h0F;
      default: lane_mask = 8'hFF;
    endcase
  endfunction

  // Low address bits that must be zero for a naturally aligned access.
  function automatic logic [2:0] align_mask(input logic [1:0] size);
    case (size)
      2'd0:    align_mask = 3'b000;
      2'd1:    align_mask = 3'b001;
      2'd2:    align_mask = 3'b011;
      default: align_mask = 3'b111;
    endcase
  endfunction

endpackage

// File: rtl/memory_memfmt.sv
// Purely combinational data formatter for the memory stage.
//   funct3  : load/store width (bits 1:0) and unsigned flag (bit 2)
//   offset  : address bits [2:0], byte lane of the access
//   wsrc    : store source register value
//   rraw    : raw 64-bit load word from the bus
//   strobe  : byte write enables for a store
//   wdata   : store data moved onto its byte lanes
//   rdata   : load value shifted down and sign/zero-extended
module memory_memfmt
  import memory_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [2:0]  offset,
  input  word_t       wsrc,
  input  word_t       rraw,
  output logic [7:0]  strobe,
  output word_t       wdata,
  output word_t       rdata
);

  logic [5:0] bit_shift;
  word_t      shifted;

  assign bit_shift = {offset, 3'b000};
  assign strobe    = lane_mask(funct3[1:0]) << offset;
  assign wdata     = wsrc << bit_shift;
  assign shifted   = rraw >> bit_shift;

  // funct3[2] selects zero extension; 64-bit loads pass through untouched.
  always_comb begin
    rdata = shifted;
    case (funct3[1:0])
      2'd0: rdata = funct3[2] ? {56'd0, shifted[7:0]}
                              : {{56{shifted[7]}}, shifted[7:0]};
      2'd1: rdata = funct3[2] ? {48'd0, shifted[15:0]}
                              : {{48{shifted[15]}}, shifted[15:0]};
      2'd2: rdata = funct3[2] ? {32'd0, shifted[31:0]}
                              : {{32{shifted[31]}}, shifted[31:0]};
      default: rdata = shifted;
    endcase
  end

endmodule

// File: rtl/memory.sv
// Pipeline memory stage.
//   clk, reset     : clock, asynchronous active-low reset
//   dataE          : record from execute
//   dataM          : registered record to writeback
//   stopm          : freezes execute and upstream while an access is pending
//   tranm          : forwarding record {data, dst, ismem}
//   dreq_*         : data bus request (valid, addr, size, strobe, data)
//   dresp_*        : data bus response (one-cycle data_ok, raw load word)
//   dbg_state      : current FSM state, for observation only
//
// Bus handshake: dreq_valid rises combinationally when an aligned load/store
// sits in dataE and stays high with all request fields stable (dataE is held
// by stopm) until the cycle dresp_data_ok pulses; that cycle completes the
// access. dresp_data_ok while dreq_valid is low is ignored.
module memory
  import memory_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  excute_data_t dataE,
  output memory_data_t dataM,
  output logic         stopm,
  output tran_t        tranm,
  output logic         dreq_valid,
  output word_t        dreq_addr,
  output msize_t       dreq_size,
  output logic [7:0]   dreq_strobe,
  output word_t        dreq_data,
  input  logic         dresp_data_ok,
  input  word_t        dresp_data,
  output mem_state_t   dbg_state
);

  mem_state_t state, state_nxt;
  dbus_req_t  req;
  dbus_resp_t resp;

  logic [2:0] funct3;
  logic       memop, is_load, misalign, issue, load_done;
  logic [7:0] fmt_strobe;
  word_t      fmt_wdata, fmt_rdata;

  assign resp.data_ok = dresp_data_ok;
  assign resp.data    = dresp_data;

  assign funct3   = dataE.raw_instr[14:12];
  assign memop    = dataE.valid & (dataE.ctl.op == OP_LD || dataE.ctl.op == OP_SD);
  assign is_load  = dataE.valid & (dataE.ctl.op == OP_LD);
  assign misalign = memop & (|(dataE.result[2:0] & align_mask(funct3[1:0])));
  // Gated by reset so a request dropped by reset does not reappear while
  // reset is still held.
  assign issue     = reset & memop & ~misalign;
  assign load_done = issue & is_load & resp.data_ok;

  memory_memfmt u_fmt (
    .funct3 (funct3),
    .offset (dataE.result[2:0]),
    .wsrc   (dataE.rd2),
    .rraw   (resp.data),
    .strobe (fmt_strobe),
    .wdata  (fmt_wdata),
    .rdata  (fmt_rdata)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (issue && !resp.data_ok) state_nxt = S_WAIT;
      S_WAIT: if (resp.data_ok)           state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs. The request is the same in IDLE and WAIT because dataE is
  // frozen while stopm is high, so the fields stay stable on their own.
  always_comb begin
    req        = '0;
    req.valid  = issue;
    req.addr   = dataE.result;
    req.size   = {1'b0, funct3[1:0]};
    req.strobe = is_load ? 8'h00 : fmt_strobe;
    req.data   = fmt_wdata;

    stopm = issue & ~resp.data_ok;

    tranm       = '0;
    tranm.data  = load_done ? fmt_rdata : dataE.result;
    tranm.dst   = (reset & dataE.ctl.regwrite & dataE.valid) ? dataE.dst : 5'd0;
    tranm.ismem = reset & is_load & ~resp.data_ok;
  end

  assign dreq_valid  = req.valid;
  assign dreq_addr   = req.addr;
  assign dreq_size   = req.size;
  assign dreq_strobe = req.strobe;
  assign dreq_data   = req.data;
  assign dbg_state   = state;

  // Writeback register: a bubble while stalled, otherwise the instruction
  // with its final result (loads take the formatted bus data, misaligned
  // accesses produce zero).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dataM <= '0;
    end else if (stopm) begin
      dataM.valid <= 1'b0;
    end else begin
      dataM.pc        <= dataE.pc;
      dataM.valid     <= dataE.valid;
      dataM.raw_instr <= dataE.raw_instr;
      dataM.ctl       <= dataE.ctl;
      dataM.dst       <= dataE.dst;
      dataM.rd2       <= dataE.rd2;
      dataM.misalign  <= misalign;
      if (misalign)     dataM.result <= '0;
      else if (is_load) dataM.result <= fmt_rdata;
      else              dataM.result <= dataE.result;
    end
  end

endmodule

// File: tb/tb_memory.sv
// Directed bench for the memory stage. Inputs are driven 1 time unit after
// the rising edge; combinational outputs are sampled 1 unit later and
// registered outputs right after the following edge.
module tb_memory;
  import memory_pkg::*;

  logic         clk;
  logic         reset;
  excute_data_t dataE;
  memory_data_t dataM;
  logic         stopm;
  tran_t        tranm;
  logic         dreq_valid;
  word_t        dreq_addr;
  msize_t       dreq_size;
  logic [7:0]   dreq_strobe;
  word_t        dreq_data;
  logic         dresp_data_ok;
  word_t        dresp_data;
  mem_state_t   dbg_state;

  int checks = 0;
  int errors = 0;

  memory dut (
    .clk           (clk),
    .reset         (reset),
    .dataE         (dataE),
    .dataM         (dataM),
    .stopm         (stopm),
    .tranm         (tranm),
    .dreq_valid    (dreq_valid),
    .dreq_addr     (dreq_addr),
    .dreq_size     (dreq_size),
    .dreq_strobe   (dreq_strobe),
    .dreq_data     (dreq_data),
    .dresp_data_ok (dresp_data_ok),
    .dresp_data    (dresp_data),
    .dbg_state     (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drivers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_op(input op_t op, input logic [2:0] f3, input logic rw,
                          input logic [4:0] dst, input word_t res, input word_t rd2);
    dataE.pc           = 64'h8000_0000 + res;
    dataE.valid        = 1'b1;
    dataE.raw_instr    = {17'd0, f3, 12'h003};
    dataE.ctl.op       = op;
    dataE.ctl.regwrite = rw;
    dataE.dst          = dst;
    dataE.rd2          = rd2;
    dataE.result       = res;
  endtask

  task automatic drive_idle();
    dataE = '0;
  endtask

  // Tests
  task automatic test_reset();
    reset = 1'b0;
    drive_idle();
    dresp_data_ok = 1'b0;
    dresp_data = '0;
    #12;
    checks++; if (dataM.valid !== 1'b0) begin errors++; $display("FAIL reset_dataM_valid: got %b want 0", dataM.valid); end
    checks++; if (dreq_valid !== 1'b0) begin errors++; $display("FAIL reset_dreq_valid: got %b want 0", dreq_valid); end
    checks++; if (stopm !== 1'b0) begin errors++; $display("FAIL reset_stopm: got %b want 0", stopm); end
    checks++; if (tranm.dst !== 5'd0) begin errors++; $display("FAIL reset_tranm_dst: got %0d want 0", tranm.dst); end
    checks++; if (dbg_state !== S_IDLE) begin errors++; $display("FAIL reset_state: got %0d want IDLE", dbg_state); end
    tick();
    reset = 1'b1;
    tick();
    checks++; if (dataM.valid !== 1'b0) begin errors++; $display("FAIL post_reset_valid: got %b want 0", dataM.valid); end
  endtask

  task automatic test_store_wait();
    drive_op(OP_SD, 3'b011, 1'b0, 5'd0, 64'h1008, 64'hDEADBEEF_01234567);
    dresp_data_ok = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (dreq_valid !== 1'b1) begin errors++; $display("FAIL sd_dreq_valid[%0d]: got %b want 1", i, dreq_valid); end
      checks++; if (stopm !== 1'b1) begin errors++; $display("FAIL sd_stopm[%0d]: got %b want 1", i, stopm); end
      checks++; if (dreq_strobe !== 8'hFF) begin errors++; $display("FAIL sd_strobe[%0d]: got %h want ff", i, dreq_strobe); end
      checks++; if (dreq_data !== 64'hDEADBEEF_01234567) begin errors++; $display("FAIL sd_data[%0d]: got %h want deadbeef01234567", i, dreq_data); end
      checks++; if (dreq_addr !== 64'h1008 || dreq_size !== 3'd3) begin errors++; $display("FAIL sd_addr_size[%0d]: got %h/%0d want 1008/3", i, dreq_addr, dreq_size); end
      checks++; if (tranm.dst !== 5'd0) begin errors++; $display("FAIL sd_tranm_dst[%0d]: got %0d want 0", i, tranm.dst); end
      tick();
      checks++; if (dataM.valid !== 1'b0) begin errors++; $display("FAIL sd_bubble[%0d]: got %b want 0", i, dataM.valid); end
      checks++; if (dbg_state !== S_WAIT) begin errors++; $display("FAIL sd_state_wait[%0d]: got %0d want WAIT", i, dbg_state); end
    end
    dresp_data_ok = 1'b1;
    #1;
    checks++; if (stopm !== 1'b0) begin errors++; $display("FAIL sd_done_stopm: got %b want 0", stopm); end
    checks++; if (dreq_valid !== 1'b1) begin errors++; $display("FAIL sd_done_dreq_valid: got %b want 1", dreq_valid); end
    tick();
    checks++; if (dataM.valid !== 1'b1 || dataM.result !== 64'h1008) begin errors++; $display("FAIL sd_writeback: got v=%b r=%h want v=1 r=1008", dataM.valid, dataM.result); end
    checks++; if (dbg_state !== S_IDLE) begin errors++; $display("FAIL sd_state_idle: got %0d want IDLE", dbg_state); end
    drive_idle();
    dresp_data_ok = 1'b0;
    tick();
    checks++; if (dataM.valid !== 1'b0) begin errors++; $display("FAIL sd_single_valid: got %b want 0", dataM.valid); end
  endtask

  task automatic test_load_format();
    logic [2:0] f3s  [7] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b110, 3'b011};
    word_t      addrs[7] = '{64'h2003, 64'h2003, 64'h2002, 64'h2002, 64'h2004, 64'h2004, 64'h2008};
    word_t      raws [7] = '{64'h00000000_80000000, 64'h00000000_80000000,
                             64'h00000000_80010000, 64'h00000000_80010000,
                             64'h89ABCDEF_00000000, 64'h89ABCDEF_00000000,
                             64'h01234567_89ABCDEF};
    word_t      exps [7] = '{64'hFFFFFFFF_FFFFFF80, 64'h00000000_00000080,
                             64'hFFFFFFFF_FFFF8001, 64'h00000000_00008001,
                             64'hFFFFFFFF_89ABCDEF, 64'h00000000_89ABCDEF,
                             64'h01234567_89ABCDEF};
    for (int i = 0; i < 7; i++) begin
      drive_op(OP_LD, f3s[i], 1'b1, 5'd3, addrs[i], 64'h0);
      dresp_data_ok = 1'b1;
      dresp_data = raws[i];
      #1;
      checks++; if (stopm !== 1'b0 || dreq_valid !== 1'b1) begin errors++; $display("FAIL ld_handshake[%0d]: got stopm=%b valid=%b want 0/1", i, stopm, dreq_valid); end
      checks++; if (dreq_strobe !== 8'h00) begin errors++; $display("FAIL ld_strobe[%0d]: got %h want 00", i, dreq_strobe); end
      checks++; if (tranm.data !== exps[i] || tranm.ismem !== 1'b0) begin errors++; $display("FAIL ld_tranm[%0d]: got %h/%b want %h/0", i, tranm.data, tranm.ismem, exps[i]); end
      tick();
      checks++; if (dataM.valid !== 1'b1 || dataM.result !== exps[i]) begin errors++; $display("FAIL ld_result[%0d]: got v=%b r=%h want v=1 r=%h", i, dataM.valid, dataM.result, exps[i]); end
      checks++; if (dbg_state !== S_IDLE) begin errors++; $display("FAIL ld_state[%0d]: got %0d want IDLE", i, dbg_state); end
    end
    drive_idle();
    dresp_data_ok = 1'b0;
    tick();
  endtask

  task automatic test_store_lanes();
    logic [2:0] f3s [3] = '{3'b001, 3'b000, 3'b010};
    word_t      adr [3] = '{64'h3006, 64'h3005, 64'h3004};
    word_t      src [3] = '{64'h0000_0000_0000_ABCD, 64'h0000_0000_0000_0012, 64'h0000_0000_1122_3344};
    logic [7:0] stb [3] = '{8'hC0, 8'h20, 8'hF0};
    word_t      dat [3] = '{64'hABCD0000_00000000, 64'h00001200_00000000, 64'h11223344_00000000};
    for (int i = 0; i < 3; i++) begin
      drive_op(OP_SD, f3s[i], 1'b0, 5'd0, adr[i], src[i]);
      dresp_data_ok = 1'b1;
      #1;
      checks++; if (dreq_strobe !== stb[i]) begin errors++; $display("FAIL st_strobe[%0d]: got %h want %h", i, dreq_strobe, stb[i]); end
      checks++; if (dreq_data !== dat[i]) begin errors++; $display("FAIL st_data[%0d]: got %h want %h", i, dreq_data, dat[i]); end
      checks++; if (dreq_size !== {1'b0, f3s[i][1:0]}) begin errors++; $display("FAIL st_size[%0d]: got %0d want %0d", i, dreq_size, f3s[i][1:0]); end
      tick();
    end
    drive_idle();
    dresp_data_ok = 1'b0;
    tick();
  endtask

  task automatic test_misalign();
    word_t adr [2] = '{64'h4002, 64'h1001};
    op_t   ops [2] = '{OP_LD, OP_SD};
    logic [2:0] f3s [2] = '{3'b010, 3'b011};
    for (int i = 0; i < 2; i++) begin
      drive_op(ops[i], f3s[i], 1'b0, 5'd0, adr[i], 64'h55);
      dresp_data_ok = 1'b0;
      #1;
      checks++; if (dreq_valid !== 1'b0 || stopm !== 1'b0) begin errors++; $display("FAIL mis_no_req[%0d]: got valid=%b stopm=%b want 0/0", i, dreq_valid, stopm); end
      tick();
      checks++; if (dataM.valid !== 1'b1 || dataM.misalign !== 1'b1 || dataM.result !== 64'h0) begin errors++; $display("FAIL mis_wb[%0d]: got v=%b m=%b r=%h want 1/1/0", i, dataM.valid, dataM.misalign, dataM.result); end
    end
    drive_idle();
    tick();
  endtask

  task automatic test_reset_mid_access();
    drive_op(OP_LD, 3'b011, 1'b1, 5'd7, 64'h5000, 64'h0);
    dresp_data_ok = 1'b0;
    #1;
    checks++; if (stopm !== 1'b1) begin errors++; $display("FAIL rst_mid_stopm: got %b want 1", stopm); end
    tick();
    checks++; if (dbg_state !== S_WAIT || dreq_valid !== 1'b1) begin errors++; $display("FAIL rst_mid_wait: got state=%0d valid=%b want WAIT/1", dbg_state, dreq_valid); end
    reset = 1'b0;
    drive_idle();
    #1;
    checks++; if (dreq_valid !== 1'b0 || stopm !== 1'b0) begin errors++; $display("FAIL rst_mid_drop: got valid=%b stopm=%b want 0/0", dreq_valid, stopm); end
    checks++; if (dataM.valid !== 1'b0 || dbg_state !== S_IDLE) begin errors++; $display("FAIL rst_mid_state: got v=%b state=%0d want 0/IDLE", dataM.valid, dbg_state); end
    tick();
    reset = 1'b1;
    dresp_data_ok = 1'b1;
    dresp_data = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    checks++; if (dreq_valid !== 1'b0 || stopm !== 1'b0) begin errors++; $display("FAIL late_ok_comb: got valid=%b stopm=%b want 0/0", dreq_valid, stopm); end
    tick();
    checks++; if (dataM.valid !== 1'b0 || dbg_state !== S_IDLE) begin errors++; $display("FAIL late_ok_ignored: got v=%b state=%0d want 0/IDLE", dataM.valid, dbg_state); end
    dresp_data_ok = 1'b0;
  endtask

  task automatic test_forward();
    drive_op(OP_ALU, 3'b000, 1'b1, 5'd5, 64'd7, 64'h0);
    #1;
    checks++; if (tranm.data !== 64'd7 || tranm.dst !== 5'd5 || tranm.ismem !== 1'b0) begin errors++; $display("FAIL fwd_alu: got {%h,%0d,%b} want {7,5,0}", tranm.data, tranm.dst, tranm.ismem); end
    checks++; if (stopm !== 1'b0 || dreq_valid !== 1'b0) begin errors++; $display("FAIL fwd_alu_noreq: got stopm=%b valid=%b want 0/0", stopm, dreq_valid); end
    tick();
    checks++; if (dataM.valid !== 1'b1 || dataM.result !== 64'd7 || dataM.dst !== 5'd5) begin errors++; $display("FAIL fwd_alu_wb: got v=%b r=%h d=%0d want 1/7/5", dataM.valid, dataM.result, dataM.dst); end
    drive_op(OP_LD, 3'b011, 1'b1, 5'd6, 64'h6000, 64'h0);
    dresp_data_ok = 1'b0;
    #1;
    checks++; if (tranm.ismem !== 1'b1 || tranm.dst !== 5'd6 || tranm.data !== 64'h6000) begin errors++; $display("FAIL fwd_ld_pending: got {%h,%0d,%b} want {6000,6,1}", tranm.data, tranm.dst, tranm.ismem); end
    tick();
    dresp_data_ok = 1'b1;
    dresp_data = 64'h11223344_55667788;
    #1;
    checks++; if (tranm.ismem !== 1'b0 || tranm.data !== 64'h11223344_55667788) begin errors++; $display("FAIL fwd_ld_done: got {%h,%b} want {1122334455667788,0}", tranm.data, tranm.ismem); end
    tick();
    checks++; if (dataM.valid !== 1'b1 || dataM.result !== 64'h11223344_55667788) begin errors++; $display("FAIL fwd_ld_wb: got v=%b r=%h want 1/1122334455667788", dataM.valid, dataM.result); end
    drive_op(OP_SD, 3'b011, 1'b0, 5'd9, 64'h7000, 64'h1);
    #1;
    checks++; if (tranm.dst !== 5'd0) begin errors++; $display("FAIL fwd_no_regwrite: got %0d want 0", tranm.dst); end
    tick();
    drive_idle();
    dresp_data_ok = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_store_wait();
    test_load_format();
    test_store_lanes();
    test_misalign();
    test_reset_mid_access();
    test_forward();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
